// File: rtl/score_bcd_encoder.sv
// Sequential double-dabble binary-to-BCD encoder, one bit per clock.
// Results and the leading-zero blank mask are registered and held between conversions.
module score_bcd_encoder #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clkin,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                done_q, done_d;

  logic [BW-1:0]       adj;
  logic [DIGITS-1:0]   mask;
  logic                lz;

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    done_d    = 1'b0;

    // Add-3 correction on every nibble before the shift keeps each digit <= 9.
    adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end

    // Leading-zero chain from the most significant digit down; digit 0 is never blanked.
    mask = '0;
    lz   = 1'b1;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      lz = lz & (scratch_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      mask[DIGITS-1-k] = lz;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[BW-2:0], shreg_q[WIDTH-1]};
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = scratch_q;
        blank_d = mask;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Directed, table-driven bench for score_bcd_encoder with hand-computed BCD results.
module tb_score_bcd_encoder;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;

  int passed = 0;
  int total  = 0;

  score_bcd_encoder #(.WIDTH(10), .DIGITS(4)) dut (
    .clkin  (clk),
    .resetn (resetn),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .blank  (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  b;
    logic [15:0] e_bcd;
    logic [3:0]  e_blank;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Entered at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [9:0] v);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
  endtask

  // Counts edges until done, checking busy and that bcd holds the previous result meanwhile.
  task automatic wait_done(input logic [15:0] prev, input int mid_at, input logic [9:0] mid_bin,
                           output int lat, output int busy_n, output logic held);
    lat    = 0;
    busy_n = 0;
    held   = 1'b1;
    while (lat < 40) begin
      if (busy) busy_n++;
      if (bcd !== prev || done) held = 1'b0;
      if (lat == mid_at) begin
        start = 1'b1;
        bin   = mid_bin;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         lat, bn;
    logic       held, ok;
    logic [15:0] prev;

    tbl[0] = '{10'd0,    16'h0000, 4'b1110};
    tbl[1] = '{10'd1023, 16'h1023, 4'b0000};
    tbl[2] = '{10'd509,  16'h0509, 4'b1000};
    tbl[3] = '{10'd7,    16'h0007, 4'b1110};
    tbl[4] = '{10'd64,   16'h0064, 4'b1100};
    tbl[5] = '{10'd10,   16'h0010, 4'b1100};
    tbl[6] = '{10'd100,  16'h0100, 4'b1000};
    tbl[7] = '{10'd999,  16'h0999, 4'b1000};
    tbl[8] = '{10'd9,    16'h0009, 4'b1110};
    tbl[9] = '{10'd1000, 16'h1000, 4'b0000};

    resetn = 1'b0;
    start  = 1'b0;
    bin    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    chk("rst_bcd",   bcd,   16'h0000);
    chk("rst_blank", blank, 4'b1110);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);

    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bin = 10'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (bcd !== 16'h0000 || blank !== 4'b1110 || busy || done) ok = 1'b0;
    end
    chk("idle_hold", ok, 1'b1);

    prev = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].b);
      wait_done(prev, -1, '0, lat, bn, held);
      chk("latency",    lat,   11);
      chk("busy_cycles", bn,   11);
      chk("bcd_held",   held,  1'b1);
      chk("bcd",        bcd,   tbl[i].e_bcd);
      chk("blank",      blank, tbl[i].e_blank);
      chk("busy_at_done", busy, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("bcd_after",  bcd,   tbl[i].e_bcd);
      prev = tbl[i].e_bcd;
    end

    // Start ignored while busy, then a back-to-back request in the done cycle.
    launch(10'd300);
    wait_done(prev, 4, 10'd999, lat, bn, held);
    chk("ign_latency", lat,   11);
    chk("ign_bcd",     bcd,   16'h0300);
    chk("ign_blank",   blank, 4'b1000);
    launch(10'd42);
    wait_done(16'h0300, -1, '0, lat, bn, held);
    chk("b2b_latency", lat,   11);
    chk("b2b_held",    held,  1'b1);
    chk("b2b_bcd",     bcd,   16'h0042);
    chk("b2b_blank",   blank, 4'b1100);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of a conversion discards it.
    launch(10'd777);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_busy", busy, 1'b1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk("mrst_busy",  busy,  1'b0);
    chk("mrst_bcd",   bcd,   16'h0000);
    chk("mrst_blank", blank, 4'b1110);
    chk("mrst_done",  done,  1'b0);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) ok = 1'b0;
    end
    chk("no_done_777", ok, 1'b1);

    launch(10'd64);
    wait_done(16'h0000, -1, '0, lat, bn, held);
    chk("post_latency", lat,   11);
    chk("post_bcd",     bcd,   16'h0064);
    chk("post_blank",   blank, 4'b1100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
